// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester round-robin arbiter for one block-RAM port.
// Grants are combinational, the RAM port is driven from registers, and a
// {valid, owner} pipeline routes each read word back to the requester that issued it.
module bram_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_regce,
    output logic              ram_rst,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

    owner_e            last_q, last_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    owner_e            iss_own_q, iss_own_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    owner_e            own_q [RD_LAT];
    owner_e            own_d [RD_LAT];

    // Round-robin grant: a lone requester wins, on contention the one not granted last wins.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && (!m1_req || last_q == OWN_M1)) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // Issue stage next state: capture the granted request, otherwise idle the port.
    always_comb begin
        last_d     = last_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        iss_own_d  = iss_own_q;
        if (m0_gnt) begin
            last_d     = OWN_M0;
            ram_en_d   = 1'b1;
            ram_we_d   = m0_we;
            ram_addr_d = m0_addr;
            ram_din_d  = m0_wdata;
            iss_own_d  = OWN_M0;
        end else if (m1_gnt) begin
            last_d     = OWN_M1;
            ram_en_d   = 1'b1;
            ram_we_d   = m1_we;
            ram_addr_d = m1_addr;
            ram_din_d  = m1_wdata;
            iss_own_d  = OWN_M1;
        end
    end

    // Read-tracking shift: stage 0 marks reads issued this cycle, later stages follow the RAM latency.
    always_comb begin
        vld_d = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            own_d[i] = OWN_M0;
        end
        vld_d[0] = ram_en_q & ~ram_we_q;
        own_d[0] = iss_own_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    // State registers with synchronous reset; reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= OWN_M1;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            iss_own_q  <= OWN_M0;
            vld_q      <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                own_q[i] <= OWN_M0;
            end
        end else begin
            last_q     <= last_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            iss_own_q  <= iss_own_d;
            vld_q      <= vld_d;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                own_q[i] <= own_d[i];
            end
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_rst   = rst;
    // The output register only exists on the two-cycle RAM; load it only for reads in flight.
    assign ram_regce = (RD_LAT == 2) ? vld_q[0] : 1'b0;

    assign m0_rvalid = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWN_M0);
    assign m1_rvalid = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWN_M1);
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: RD_LAT=2 and RD_LAT=1 instances share
// the same requester stimulus, each attached to its own behavioural RAM.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [9:0]  m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;

    logic        m0_gnt2, m1_gnt2, m0_rvalid2, m1_rvalid2;
    logic [15:0] m0_rdata2, m1_rdata2, ram_din2, ram_dout2, lat2;
    logic        ram_en2, ram_we2, ram_regce2, ram_rst2;
    logic [9:0]  ram_addr2;

    logic        m0_gnt1, m1_gnt1, m0_rvalid1, m1_rvalid1;
    logic [15:0] m0_rdata1, m1_rdata1, ram_din1, ram_dout1;
    logic        ram_en1, ram_we1, ram_regce1, ram_rst1;
    logic [9:0]  ram_addr1;

    logic [15:0] mem2 [1024];
    logic [15:0] mem1 [1024];
    logic        regce1_seen = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DATA_W(16), .ADDR_W(10), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt2), .m0_rvalid(m0_rvalid2), .m0_rdata(m0_rdata2),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt2), .m1_rvalid(m1_rvalid2), .m1_rdata(m1_rdata2),
        .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
        .ram_regce(ram_regce2), .ram_rst(ram_rst2), .ram_dout(ram_dout2)
    );

    bram_port_arbiter #(.DATA_W(16), .ADDR_W(10), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt1), .m0_rvalid(m0_rvalid1), .m0_rdata(m0_rdata1),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt1), .m1_rvalid(m1_rvalid1), .m1_rdata(m1_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_regce(ram_regce1), .ram_rst(ram_rst1), .ram_dout(ram_dout1)
    );

    // High-performance RAM: no-change latch stage plus output register gated by regce.
    always @(posedge clk) begin
        if (ram_en2) begin
            if (ram_we2) mem2[ram_addr2] <= ram_din2;
            else         lat2 <= mem2[ram_addr2];
        end
        if (ram_rst2)        ram_dout2 <= '0;
        else if (ram_regce2) ram_dout2 <= lat2;
    end

    // Low-latency RAM: no-change read port, dout one cycle after the enable edge.
    always @(posedge clk) begin
        if (ram_rst1) begin
            ram_dout1 <= '0;
        end else if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_din1;
            else         ram_dout1 <= mem1[ram_addr1];
        end
        if (ram_regce1 !== 1'b0) regce1_seen <= 1'b1;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2, m0_gnt1, m1_gnt1} !== 4'b0000) begin
            n_err++; $display("FAIL rst_gnt: got %b want 0000", {m0_gnt2, m1_gnt2, m0_gnt1, m1_gnt1});
        end
        n_cmp++;
        if (ram_rst2 !== 1'b1) begin n_err++; $display("FAIL rst_ramrst: got %b want 1", ram_rst2); end
        @(negedge clk);
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en2, ram_we2, ram_regce2, m0_rvalid2, m1_rvalid2, ram_rst2} !== 6'b0) begin
            n_err++; $display("FAIL rst_ctl2: got %b want 000000",
                              {ram_en2, ram_we2, ram_regce2, m0_rvalid2, m1_rvalid2, ram_rst2});
        end
        n_cmp++;
        if ({ram_addr2, ram_din2} !== 26'h0) begin
            n_err++; $display("FAIL rst_addr_din: got %h/%h want 0/0", ram_addr2, ram_din2);
        end
        n_cmp++;
        if ({ram_en1, ram_we1, ram_regce1, m0_rvalid1, m1_rvalid1} !== 5'b0) begin
            n_err++; $display("FAIL rst_ctl1: got %b want 00000",
                              {ram_en1, ram_we1, ram_regce1, m0_rvalid1, m1_rvalid1});
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'd5; m0_wdata = 16'hABCD;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", {m0_gnt2, m1_gnt2}); end
        @(negedge clk);
        m0_we = 1'b0;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2} !== 2'b10) begin n_err++; $display("FAIL rd_gnt: got %b want 10", {m0_gnt2, m1_gnt2}); end
        n_cmp++;
        if ({ram_en2, ram_we2, ram_addr2, ram_din2} !== {1'b1, 1'b1, 10'd5, 16'hABCD}) begin
            n_err++; $display("FAIL wr_issue: got en=%b we=%b a=%h d=%h want 1 1 005 abcd",
                              ram_en2, ram_we2, ram_addr2, ram_din2);
        end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en2, ram_we2, ram_addr2} !== {1'b1, 1'b0, 10'd5}) begin
            n_err++; $display("FAIL rd_issue: got en=%b we=%b a=%h want 1 0 005", ram_en2, ram_we2, ram_addr2);
        end
        // Read granted in cycle 1: RD_LAT=2 returns in cycle 4, RD_LAT=1 in cycle 3.
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({m0_rvalid2, m1_rvalid2, ram_regce2} !== {k == 4, 1'b0, k == 3}) begin
                n_err++; $display("FAIL wr_rd_valid2 c%0d: got %b want %b", k,
                                  {m0_rvalid2, m1_rvalid2, ram_regce2}, {k == 4, 1'b0, k == 3});
            end
            n_cmp++;
            if ({m0_rvalid1, m1_rvalid1} !== {k == 3, 1'b0}) begin
                n_err++; $display("FAIL wr_rd_valid1 c%0d: got %b want %b", k,
                                  {m0_rvalid1, m1_rvalid1}, {k == 3, 1'b0});
            end
            if (k == 4) begin
                n_cmp++;
                if (m0_rdata2 !== 16'hABCD) begin n_err++; $display("FAIL wr_rd_data2: got %h want abcd", m0_rdata2); end
            end
            if (k == 3) begin
                n_cmp++;
                if (m0_rdata1 !== 16'hABCD) begin n_err++; $display("FAIL wr_rd_data1: got %h want abcd", m0_rdata1); end
            end
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp;
        test_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
            m0_addr = 10'd0; m1_addr = 10'd0;
            #1;
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({m0_gnt2, m1_gnt2} !== exp) begin n_err++; $display("FAIL cont_gnt2 c%0d: got %b want %b", k, {m0_gnt2, m1_gnt2}, exp); end
            n_cmp++;
            if ({m0_gnt1, m1_gnt1} !== exp) begin n_err++; $display("FAIL cont_gnt1 c%0d: got %b want %b", k, {m0_gnt1, m1_gnt1}, exp); end
        end
        idle(5);
    endtask

    task automatic test_interleaved;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'd1; m0_wdata = 16'h0011;
        @(negedge clk);
        m0_addr = 10'd2; m0_wdata = 16'h0022;
        @(negedge clk);
        m0_we = 1'b0; m0_addr = 10'd1;
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd2;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2} !== 2'b01) begin n_err++; $display("FAIL il_gnt: got %b want 01", {m0_gnt2, m1_gnt2}); end
        // m0 read granted in cycle 2, m1 read in cycle 3.
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            m1_req = 1'b0;
            #1;
            n_cmp++;
            if ({m0_rvalid2, m1_rvalid2} !== {k == 5, k == 6}) begin
                n_err++; $display("FAIL il_valid2 c%0d: got %b want %b", k, {m0_rvalid2, m1_rvalid2}, {k == 5, k == 6});
            end
            n_cmp++;
            if ({m0_rvalid1, m1_rvalid1} !== {k == 4, k == 5}) begin
                n_err++; $display("FAIL il_valid1 c%0d: got %b want %b", k, {m0_rvalid1, m1_rvalid1}, {k == 4, k == 5});
            end
            if (k == 5) begin
                n_cmp++;
                if (m0_rdata2 !== 16'h0011) begin n_err++; $display("FAIL il_data_m0: got %h want 0011", m0_rdata2); end
                n_cmp++;
                if (m1_rdata1 !== 16'h0022) begin n_err++; $display("FAIL il_data1_m1: got %h want 0022", m1_rdata1); end
            end
            if (k == 6) begin
                n_cmp++;
                if (m1_rdata2 !== 16'h0022) begin n_err++; $display("FAIL il_data_m1: got %h want 0022", m1_rdata2); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            m0_req = 1'b0; m1_req = 1'b0;
            case (k)
                0: begin m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'd7; m0_wdata = 16'h0777; end
                1: begin m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd2; end
                2: begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd7; end
                3: begin m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd9; m1_wdata = 16'h0999; end
                default: ;
            endcase
            #1;
            if (k >= 1) begin
                n_cmp++;
                if ({ram_en2, ram_we2} !== {(k <= 4), (k == 1 || k == 4)}) begin
                    n_err++; $display("FAIL b2b_issue c%0d: got %b want %b", k, {ram_en2, ram_we2},
                                      {(k <= 4), (k == 1 || k == 4)});
                end
                n_cmp++;
                if ({m0_rvalid2, m1_rvalid2} !== {k == 5, k == 4}) begin
                    n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", k, {m0_rvalid2, m1_rvalid2}, {k == 5, k == 4});
                end
            end
            pulses += int'(m0_rvalid2) + int'(m1_rvalid2);
            if (k == 4) begin
                n_cmp++;
                if (m1_rdata2 !== 16'h0022) begin n_err++; $display("FAIL b2b_data_m1: got %h want 0022", m1_rdata2); end
            end
            if (k == 5) begin
                n_cmp++;
                if (m0_rdata2 !== 16'h0777) begin n_err++; $display("FAIL b2b_data_m0: got %h want 0777", m0_rdata2); end
            end
        end
        n_cmp++;
        if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5;
        @(negedge clk);
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2} !== 2'b00) begin n_err++; $display("FAIL rmr_gnt_in_rst: got %b want 00", {m0_gnt2, m1_gnt2}); end
        @(negedge clk);
        rst = 1'b0;
        m0_we = 1'b1; m0_addr = 10'd3; m0_wdata = 16'h0033;
        m1_we = 1'b1; m1_addr = 10'd4; m1_wdata = 16'h0044;
        #1;
        n_cmp++;
        if ({m0_gnt2, m1_gnt2} !== 2'b10) begin n_err++; $display("FAIL rmr_first_gnt: got %b want 10", {m0_gnt2, m1_gnt2}); end
        n_cmp++;
        if ({ram_en2, ram_we2, ram_addr2, ram_din2, ram_regce2} !== 29'h0) begin
            n_err++; $display("FAIL rmr_outputs: got en=%b we=%b a=%h d=%h ce=%b want all 0",
                              ram_en2, ram_we2, ram_addr2, ram_din2, ram_regce2);
        end
        for (int k = 2; k <= 7; k++) begin
            n_cmp++;
            if ({m0_rvalid2, m1_rvalid2, m0_rvalid1, m1_rvalid1} !== 4'b0000) begin
                n_err++; $display("FAIL rmr_no_valid c%0d: got %b want 0000", k,
                                  {m0_rvalid2, m1_rvalid2, m0_rvalid1, m1_rvalid1});
            end
            @(negedge clk);
            m0_req = 1'b0; m1_req = 1'b0;
            #1;
        end
    endtask

    task automatic test_regce_lat1;
        n_cmp++;
        if (regce1_seen !== 1'b0) begin n_err++; $display("FAIL lat1_regce: got %b want 0", regce1_seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem2[i] = '0;
            mem1[i] = '0;
        end
        test_reset();
        test_write_read();
        test_contention();
        test_interleaved();
        test_back_to_back();
        test_reset_mid_read();
        test_regce_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
